// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/stop serializer
// with a 16-tick-per-bit baud timer. Divisor and stop-bit mode are latched per frame.
module uart_tx_buffered #(
  parameter int DATA_SIZE     = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int BAUD_DIV_SIZE = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_SIZE-1:0]               wr_data_i,
  input  logic                               wr_valid_i,
  output logic                               wr_ready_o,
  input  logic                               two_stop_bits_i,
  input  logic [BAUD_DIV_SIZE-1:0]           baud_div_i,
  input  logic                               tx_en_i,
  output logic                               tx_pin_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o,
  output logic                               fifo_empty_o,
  output logic                               fifo_full_o,
  output logic                               busy_o,
  output logic                               tx_done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int BIT_W = $clog2(DATA_SIZE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state, state_n;
  logic [DATA_SIZE-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wptr, rptr;
  logic [CNT_W-1:0]           count;
  logic                       push, pop;
  logic [DATA_SIZE-1:0]       shift;
  logic [BIT_W-1:0]           bit_idx;
  logic [BAUD_DIV_SIZE-1:0]   div_q, tick_cnt;
  logic [3:0]                 sub_cnt;
  logic                       two_q, stop_idx;
  logic                       pin, pin_n, done, done_n;
  logic                       tick, bit_end;

  // Flags depend only on the count register, so ready never looks at wr_valid_i.
  assign fifo_full_o  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_o = (count == '0);
  assign wr_ready_o   = ~fifo_full_o;
  assign fifo_count_o = count;
  assign push         = wr_valid_i & wr_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data_i;
  end

  assign tick    = (tick_cnt == '0);
  assign bit_end = tick & (sub_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    pin_n   = pin;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        pin_n = 1'b1;
        if (tx_en_i & ~fifo_empty_o) begin
          pop     = 1'b1;
          state_n = START;
          pin_n   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          pin_n   = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_W'(DATA_SIZE-1)) begin
            state_n = STOP;
            pin_n   = 1'b1;
          end else begin
            pin_n = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end && (stop_idx == two_q)) begin
          done_n = 1'b1;
          // Chain straight into the next start bit when more data is waiting.
          if (tx_en_i & ~fifo_empty_o) begin
            pop     = 1'b1;
            state_n = START;
            pin_n   = 1'b0;
          end else begin
            state_n = IDLE;
            pin_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        pin_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      bit_idx  <= '0;
      div_q    <= '0;
      tick_cnt <= '0;
      sub_cnt  <= '0;
      two_q    <= 1'b0;
      stop_idx <= 1'b0;
      pin      <= 1'b1;
      done     <= 1'b0;
    end else begin
      pin  <= pin_n;
      done <= done_n;
      if (pop) begin
        shift    <= mem[rptr];
        div_q    <= baud_div_i;
        two_q    <= two_stop_bits_i;
        tick_cnt <= baud_div_i;
        sub_cnt  <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else if (state != IDLE) begin
        if (tick) begin
          tick_cnt <= div_q;
          sub_cnt  <= sub_cnt + 1'b1;
        end else begin
          tick_cnt <= tick_cnt - 1'b1;
        end
        if (bit_end && state == DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
        if (bit_end && state == STOP) stop_idx <= 1'b1;
      end
    end
  end

  assign tx_pin_o  = pin;
  assign tx_done_o = done;
  assign busy_o    = (state != IDLE);

endmodule
